// File: rtl/mem_responder_pkg.sv
// ============================================================================
//  Module   : mem_responder_pkg
//  Purpose  : Shared word width, responder state encoding and address-range
//             helper for the mem_responder slice.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_responder_pkg;

   // Width of one stored word and of the rdata/wdata buses
   localparam int c_WORD = 16;

   // Responder handshake states
   localparam logic [1:0] c_ST_IDLE    = 2'd0;
   localparam logic [1:0] c_ST_WAIT    = 2'd1;
   localparam logic [1:0] c_ST_RESPOND = 2'd2;
   localparam logic [1:0] c_ST_RELEASE = 2'd3;

   // True when a zero-extended word address maps onto real storage
   function automatic logic in_range(input logic [31:0] a, input int depth);
      return a < 32'(depth);
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_responder_mem_array.sv
// ============================================================================
//  Module   : mem_array
//  Purpose  : DEPTH x WIDTH word storage, synchronous write, combinational
//             read. Out-of-range reads return zero, out-of-range writes are
//             ignored. Contents are deliberately not reset.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_array
   import mem_responder_pkg::*;
#(
   parameter int DEPTH  = 31,
   parameter int ADDR_W = 5,
   parameter int WIDTH  = c_WORD
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_in_range;

   assign w_in_range = in_range(32'(addr), DEPTH);

   // Storage write; no reset so contents survive a responder reset
   always_ff @(posedge clk) begin
      if (we && w_in_range) begin
         r_mem[addr] <= wdata;
      end
   end

   // Combinational read with zero for addresses beyond the array
   always_comb begin
      rdata = '0;
      if (w_in_range) begin
         rdata = r_mem[addr];
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
//  Module   : mem_responder
//  Purpose  : Four-phase req/mfc memory responder with programmable wait
//             states in front of a mem_array word store.
//  Options  : MEM_RESPONDER_ERR_EN - when defined, out-of-range accesses
//             complete with err=1; otherwise err is held at 0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int DEPTH       = 31,
   parameter int ADDR_W      = 5,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [c_WORD-1:0] wdata,
   output logic [c_WORD-1:0] rdata,
   output logic              mfc,
   output logic              busy,
   output logic              err
);

`ifdef MEM_RESPONDER_ERR_EN
   localparam logic c_ERR_EN = 1'b1;
`else
   localparam logic c_ERR_EN = 1'b0;
`endif

   logic [1:0]        r_state;
   logic [3:0]        r_cnt;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [c_WORD-1:0] r_wdata;
   logic [c_WORD-1:0] r_rdata;
   logic              r_err;

   logic              w_exec;
   logic              w_in_range;
   logic              w_mem_we;
   logic [c_WORD-1:0] w_mem_rdata;

   // The access happens exactly once, on the edge that leaves WAIT
   assign w_exec     = (r_state == c_ST_WAIT) && (r_cnt == 4'd0);
   assign w_in_range = in_range(32'(r_addr), DEPTH);
   assign w_mem_we   = w_exec && r_we && w_in_range;

   mem_array #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .WIDTH  (c_WORD)
   ) u_mem (
      .clk   (clk),
      .we    (w_mem_we),
      .addr  (r_addr),
      .wdata (r_wdata),
      .rdata (w_mem_rdata)
   );

   // Handshake state machine, request latch, wait counter and response regs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_ST_IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (req) begin
                  r_we    <= we;
                  r_addr  <= addr;
                  r_wdata <= wdata;
                  r_cnt   <= 4'(WAIT_CYCLES);
                  r_state <= c_ST_WAIT;
               end
            end
            c_ST_WAIT: begin
               if (r_cnt == 4'd0) begin
                  // Writes leave rdata untouched; out-of-range reads give zero
                  if (!r_we) begin
                     r_rdata <= w_in_range ? w_mem_rdata : '0;
                  end
                  r_err   <= c_ERR_EN & ~w_in_range;
                  r_state <= c_ST_RESPOND;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            c_ST_RESPOND: begin
               // An early req drop falls straight through after one cycle
               if (!req) begin
                  r_state <= c_ST_RELEASE;
               end
            end
            default: begin
               // RELEASE: one guaranteed idle cycle before the next accept
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

   assign mfc   = (r_state == c_ST_RESPOND);
   assign busy  = (r_state == c_ST_WAIT) || (r_state == c_ST_RESPOND);
   assign rdata = r_rdata;
   // Constant-zero when the error option is not built in
   assign err   = r_err;

endmodule

`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 31, number of 16-bit words stored (addresses 0..DEPTH-1).
REQ-002 SHALL have parameter ADDR_W, default 5, address width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, wait states inserted before each response (range 0..15).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port req  input  1  initiator request; held high until mfc seen.
REQ-007 SHALL have port we  input  1  1=write, 0=read; sampled with req.
REQ-008 SHALL have port addr  input  ADDR_W  word address; sampled with req.
REQ-009 SHALL have port wdata  input  16  write data; sampled with req.
REQ-010 SHALL have port rdata  output  16  read data; valid while mfc=1 on a read.
REQ-011 SHALL have port mfc  output  1  memory-function-complete acknowledge.
REQ-012 SHALL have port busy  output  1  high from request acceptance until return to IDLE.
REQ-013 SHALL have port err  output  1  out-of-range flag; qualified by mfc.

Function
REQ-014 SHALL implement the four-phase handshake: req rises -> mfc rises -> req falls -> mfc falls.
REQ-015 SHALL use states IDLE, WAIT, RESPOND, RELEASE.
REQ-016 IDLE: req=1 at an edge SHALL latch we/addr/wdata, load the wait counter with WAIT_CYCLES and enter WAIT; busy=1.
REQ-017 WAIT: the counter SHALL decrement each cycle; at zero the access SHALL execute and the state SHALL become RESPOND.
REQ-018 With WAIT_CYCLES=0, WAIT SHALL last exactly one cycle, so mfc rises on the edge after acceptance.
REQ-019 Latency: req accepted at edge N -> mfc=1 after edge N+WAIT_CYCLES+1.
REQ-020 A write SHALL commit to storage on the WAIT->RESPOND edge only; a read SHALL register rdata on that same edge.
REQ-021 RESPOND: mfc=1; it SHALL hold rdata/err stable while req=1; on req=0 it SHALL enter RELEASE.
REQ-022 RELEASE: mfc=0, busy=0, then IDLE; a new req SHALL NOT be accepted in RELEASE (min 1 idle cycle between transactions).
REQ-023 Changes of we/addr/wdata after acceptance SHALL be ignored.
REQ-024 req dropping during WAIT (protocol violation) SHALL NOT abort; the access SHALL complete, and RESPOND SHALL pass directly to RELEASE.
REQ-025 On a write, rdata SHALL keep its previous value.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, mfc=0, busy=0, err=0, rdata=16'h0000, counter=0.
REQ-027 Reset during WAIT SHALL discard the pending write; storage contents SHALL NOT be cleared by reset.

Configuration
REQ-028 With MEM_RESPONDER_ERR_EN defined, addr>=DEPTH SHALL complete the handshake with err=1, rdata=16'h0000, and the write dropped.
REQ-029 Without MEM_RESPONDER_ERR_EN, err SHALL be tied 0; out-of-range reads SHALL return 16'h0000 and out-of-range writes SHALL be dropped silently.

Structure
REQ-030 The shared package SHALL hold the WORD width (16) and the responder state encoding.
REQ-031 Storage SHALL be one sub-module, mem_array (synchronous write, combinational read, DEPTH x 16).

Verification
REQ-032 Read, WAIT_CYCLES=2: preload addr 3=16'hA5A5, req at edge 0 -> mfc=1 after edge 3, rdata=16'hA5A5, err=0.
REQ-033 Write then read: write 16'h1234 to addr 7, complete the handshake, then read addr 7 -> rdata=16'h1234; rdata unchanged during the write.
REQ-034 WAIT_CYCLES=0: req accepted at edge 0 -> mfc=1 after edge 1; req held 3 more cycles -> mfc stays 1 with rdata stable; req low -> mfc=0 next edge.
REQ-035 Back-to-back: req re-asserted in the cycle mfc falls -> not accepted until the following edge; busy=0 for one cycle.
REQ-036 Reset mid-write: rst_n low during WAIT of a write of 16'hFFFF to addr 2 (old value 16'h0001) -> mfc=0, busy=0 immediately; subsequent read of addr 2 = 16'h0001.
REQ-037 Out of range, MEM_RESPONDER_ERR_EN defined: read addr 31 -> mfc=1, err=1, rdata=16'h0000; undefined -> err=0, rdata=16'h0000.
